// File: rtl/uart_tx_ctrl_pkg.sv
// Shared types and line levels for the UART transmit frame sequencer.
// Imported by uart_tx_ctrl and its interface/sub-modules.
package uart_tx_pkg;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Byte-in / serial-out bundle of the UART transmitter.
// master = byte source + parity calculator side, slave = uart_tx_ctrl.
interface uart_tx_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  Data_valid;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  PAR_EN;
    logic                  par_bit;
    logic                  TX_OUT;
    logic                  busy;

    modport master (
        output Data_valid,
        output P_DATA,
        output PAR_EN,
        output par_bit,
        input  TX_OUT,
        input  busy
    );

    modport slave (
        input  Data_valid,
        input  P_DATA,
        input  PAR_EN,
        input  par_bit,
        output TX_OUT,
        output busy
    );

endinterface

// File: rtl/uart_tx_serializer.sv
// Payload shift register and bit counter for the UART transmitter.
// ser_bit is the bit to put on the line on the next cycle.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  ser_en,
    output logic                  ser_bit,
    output logic                  ser_done
);

    localparam int CW = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        unique case (1'b1)
            load: begin
                shift_d = load_data;
                cnt_d   = '0;
            end
            ser_en: begin
                shift_d = shift_q >> 1;
                cnt_d   = cnt_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    // While shifting, bit 0 is already on the line; look one ahead.
    assign ser_bit  = ser_en ? shift_q[1] : shift_q[0];
    assign ser_done = (cnt_q == CW'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: FSM, registered output mux, busy flag.
// Define UART_TX_TWO_STOP_EN for a two-cycle stop bit.
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    uart_tx_ctrl_if.slave bus
);

    tx_state_e state_q, state_d;
    logic      tx_q, tx_d;
    logic      busy_q, busy_d;
    logic      par_en_q, par_en_d;
    logic      load;
    logic      ser_en;
    logic      ser_bit;
    logic      ser_done;
    logic      last_stop;

`ifdef UART_TX_TWO_STOP_EN
    logic      stop2_q, stop2_d;
    assign last_stop = stop2_q;
`else
    assign last_stop = 1'b1;
`endif

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (bus.P_DATA),
        .ser_en    (ser_en),
        .ser_bit   (ser_bit),
        .ser_done  (ser_done)
    );

    always_comb begin
        state_d  = state_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
        par_en_d = par_en_q;
        load     = 1'b0;
        ser_en   = 1'b0;
`ifdef UART_TX_TWO_STOP_EN
        stop2_d  = stop2_q;
`endif
        unique case (state_q)
            IDLE: begin
                tx_d   = IDLE_LEVEL;
                busy_d = 1'b0;
                if (bus.Data_valid) begin
                    state_d  = START;
                    load     = 1'b1;
                    par_en_d = bus.PAR_EN;
                    busy_d   = 1'b1;
                    tx_d     = START_BIT;
                end
            end
            START: begin
                state_d = DATA;
                tx_d    = ser_bit;
            end
            DATA: begin
                ser_en = 1'b1;
                if (!ser_done) begin
                    tx_d = ser_bit;
                end else if (par_en_q) begin
                    state_d = PARITY;
                    tx_d    = bus.par_bit;
                end else begin
                    state_d = STOP;
                    tx_d    = STOP_BIT;
                end
            end
            PARITY: begin
                state_d = STOP;
                tx_d    = STOP_BIT;
            end
            STOP: begin
`ifdef UART_TX_TWO_STOP_EN
                stop2_d = ~stop2_q;
`endif
                tx_d = STOP_BIT;
                if (last_stop) begin
                    state_d = IDLE;
                    tx_d    = IDLE_LEVEL;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = IDLE_LEVEL;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            tx_q     <= IDLE_LEVEL;
            busy_q   <= 1'b0;
            par_en_q <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
            stop2_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            par_en_q <= par_en_d;
`ifdef UART_TX_TWO_STOP_EN
            stop2_q  <= stop2_d;
`endif
        end
    end

    assign bus.TX_OUT = tx_q;
    assign bus.busy   = busy_q;

    // Line level must follow the frame slot the FSM is in.
    a_start_low : assert property (
        @(posedge clk) disable iff (!rst)
        (state_q == START) |-> (tx_q == START_BIT)
    );

    a_stop_high : assert property (
        @(posedge clk) disable iff (!rst)
        (state_q == STOP) |-> (tx_q == STOP_BIT)
    );

    a_idle_quiet : assert property (
        @(posedge clk) disable iff (!rst)
        (state_q == IDLE) |-> (tx_q == IDLE_LEVEL && !busy_q)
    );

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: frame model plus directed frames.
// Works with or without UART_TX_TWO_STOP_EN.
module tb_uart_tx_ctrl;

`ifdef UART_TX_TWO_STOP_EN
    localparam int NSTOP = 2;
`else
    localparam int NSTOP = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic par_typ = 1'b0;
    int   pass_cnt = 0;
    int   chk_cnt  = 0;

    logic [1:0]  exp_q[$];
    logic [1:0]  cur = 2'b10;
    logic [11:0] seq;
    int          nb;

    uart_tx_ctrl_if #(.DATA_WIDTH(8)) bus ();

    uart_tx_ctrl #(
        .DATA_WIDTH (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        else
            pass_cnt++;
    endtask

    function automatic logic [11:0] with_stops(input logic [11:0] b);
`ifdef UART_TX_TWO_STOP_EN
        return {b[10:0], 1'b1};
`else
        return b;
`endif
    endfunction

    // Frame model: {tx, busy} for every cycle after the accept edge.
    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                exp_q.delete();
                cur = 2'b10;
            end else if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
            end else if (!cur[0] && bus.Data_valid) begin
                exp_q.push_back(2'b01);
                for (int i = 0; i < 8; i++)
                    exp_q.push_back({bus.P_DATA[i], 1'b1});
                if (bus.PAR_EN)
                    exp_q.push_back({^bus.P_DATA ^ par_typ, 1'b1});
                for (int i = 0; i < NSTOP; i++)
                    exp_q.push_back(2'b11);
                cur = exp_q.pop_front();
            end else begin
                cur = 2'b10;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("cycle", {30'd0, bus.TX_OUT, bus.busy}, {30'd0, cur});
        end
    end

    task automatic send(input logic [7:0] d, input logic pe,
                        input logic pt, input int inj_a, input int inj_b,
                        input int rst_at, output logic [11:0] s,
                        output int nbusy);
        int flen;
        flen  = 9 + NSTOP + int'(pe);
        s     = '0;
        nbusy = 0;
        par_typ        = pt;
        bus.P_DATA     = d;
        bus.PAR_EN     = pe;
        bus.par_bit    = ^d ^ pt;
        bus.Data_valid = 1'b1;
        for (int i = 1; i <= flen; i++) begin
            @(negedge clk);
            s     = {s[10:0], bus.TX_OUT};
            nbusy = nbusy + int'(bus.busy);
            bus.Data_valid = 1'b0;
            if (i == inj_a || i == inj_b) begin
                bus.Data_valid = 1'b1;
                bus.P_DATA     = 8'h3C;
                bus.PAR_EN     = ~pe;
            end
            if (i == rst_at) begin
                rst = 1'b0;
                #1;
                chk("rst_tx", 32'(bus.TX_OUT), 32'd1);
                chk("rst_busy", 32'(bus.busy), 32'd0);
                @(negedge clk);
                rst = 1'b1;
                return;
            end
        end
        @(negedge clk);
        bus.Data_valid = 1'b0;
        chk("idle_gap", {30'd0, bus.TX_OUT, bus.busy}, 32'h2);
    endtask

    initial begin
        bus.Data_valid = 1'b0;
        bus.P_DATA     = 8'h00;
        bus.PAR_EN     = 1'b0;
        bus.par_bit    = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_tx", 32'(bus.TX_OUT), 32'd1);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        send(8'hA5, 1'b1, 1'b0, 0, 0, 0, seq, nb);
        chk("a5_seq", 32'(seq), 32'(with_stops(12'b0010_1001_0101)));
        chk("a5_busy", 32'(nb), 32'(10 + NSTOP));

        send(8'h01, 1'b1, 1'b1, 0, 0, 0, seq, nb);
        chk("01_seq", 32'(seq), 32'(with_stops(12'b0010_0000_0001)));
        chk("01_par", 32'(seq[NSTOP]), 32'd0);

        send(8'h03, 1'b1, 1'b1, 0, 0, 0, seq, nb);
        chk("03_seq", 32'(seq), 32'(with_stops(12'b0011_0000_0011)));
        chk("03_par", 32'(seq[NSTOP]), 32'd1);

        send(8'hFF, 1'b0, 1'b0, 0, 0, 0, seq, nb);
        chk("ff_seq", 32'(seq), 32'(with_stops(12'b0001_1111_1111)));
        chk("ff_busy", 32'(nb), 32'(9 + NSTOP));

        send(8'hA5, 1'b0, 1'b0, 6, 9 + NSTOP, 0, seq, nb);
        chk("drop_seq", 32'(seq), 32'(with_stops(12'b0001_0100_1011)));
        chk("drop_busy", 32'(nb), 32'(9 + NSTOP));
        repeat (3) begin
            @(negedge clk);
            chk("drop_quiet", {30'd0, bus.TX_OUT, bus.busy}, 32'h2);
        end

        send(8'hC3, 1'b0, 1'b0, 0, 0, 5, seq, nb);
        @(negedge clk);
        send(8'h55, 1'b1, 1'b0, 0, 0, 0, seq, nb);
        chk("55_seq", 32'(seq), 32'(with_stops(12'b0010_1010_1001)));
        chk("55_busy", 32'(nb), 32'(10 + NSTOP));

        send(8'h00, 1'b0, 1'b0, 0, 0, 0, seq, nb);
        chk("00_seq", 32'(seq), 32'(with_stops(12'b0000_0000_0001)));
        chk("00_busy", 32'(nb), 32'(9 + NSTOP));
        send(8'h81, 1'b0, 1'b0, 0, 0, 0, seq, nb);
        chk("b2b_seq", 32'(seq), 32'(with_stops(12'b0001_0000_0011)));

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
